out_data_misr: RTL
==================

OUT_DATA_MISR -- requirements
Module: out_data_misr

Interface
REQ-001 SHALL have parameter DATA_W, default 96, the width of the response vector taken from the fuzz design's out_data.
REQ-002 SHALL have parameter SIG_W, default 32, the signature width.
REQ-003 SHALL have parameter CNT_W, default 16, the width of the vector counter.
REQ-004 SHALL have parameter SEED, default 32'hFFFF_FFFF, the signature initial value.
REQ-005 SHALL have parameter POLY, default 32'h0040_0007, the feedback polynomial x^32+x^22+x^2+x+1.
REQ-006 SHALL have port clk, input, 1 bit: single clock, rising-edge.
REQ-007 SHALL have port rst, input, 1 bit: one clock; reset is asynchronous and active-high.
REQ-008 SHALL have port start, input, 1 bit: one-cycle pulse that begins a compaction run.
REQ-009 SHALL have port num_vecs, input, CNT_W bits: number of beats to compact; sampled when start is accepted.
REQ-010 SHALL have port resp_valid, input, 1 bit: resp_data is valid.
REQ-011 SHALL have port resp_ready, output, 1 bit: block accepts a beat.
REQ-012 SHALL have port resp_data, input, DATA_W bits: DUT out_data sample.
REQ-013 SHALL have port exp_sig, input, SIG_W bits: golden signature for comparison.
REQ-014 SHALL have port sig, output, SIG_W bits: current signature register.
REQ-015 SHALL have port vec_cnt, output, CNT_W bits: beats accepted in the current run.
REQ-016 SHALL have port done, output, 1 bit: run complete.
REQ-017 SHALL have port pass, output, 1 bit: done and sig==exp_sig.

Function
REQ-018 SHALL implement FSM states IDLE, RUN and DONE.
REQ-019 SHALL handle start: in IDLE or DONE, start loads target<=num_vecs, sig<=SEED and vec_cnt<=0; in RUN, start is ignored.
REQ-020 SHALL move from IDLE/DONE on start to RUN when num_vecs!=0, otherwise directly to DONE with sig=SEED.
REQ-021 SHALL drive resp_ready=1 only in RUN, combinationally from state and independent of resp_valid.
REQ-022 SHALL treat a beat as accepted when resp_valid & resp_ready is high at a rising clk edge.
REQ-023 SHALL fold each accepted beat as fold = resp_data[31:0] ^ resp_data[63:32] ^ resp_data[95:64]; for other DATA_W, the input is zero-extended to a multiple of SIG_W and all slices are XORed.
REQ-024 SHALL update the signature on each accepted beat as sig <= {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ fold.
REQ-025 SHALL increment vec_cnt on each accepted beat, modulo 2^CNT_W with no saturation.
REQ-026 SHALL, when the beat accepted makes vec_cnt==target, transition RUN->DONE at that edge, so that done=1 in the next cycle and resp_ready=0 from that cycle.
REQ-027 SHALL hold sig, vec_cnt and done stable in DONE until the next start or rst.
REQ-028 SHALL drive pass = done & (sig==exp_sig), combinationally, so that exp_sig changes in DONE are reflected immediately.
REQ-029 SHALL hold sig and vec_cnt unchanged in any RUN cycle with resp_valid=0.
REQ-030 SHALL compact back-to-back beats at full throughput, one per cycle.
REQ-031 SHALL, when start coincides with a beat in DONE, perform only the start action; no beat is accepted because resp_ready=0.

Reset
REQ-032 SHALL, on asynchronous rst assertion at any time including mid-run, force state=IDLE, sig=SEED, vec_cnt=0, done=0, pass=0 and resp_ready=0 immediately, without waiting for clk.
REQ-033 SHALL be released from rst synchronously to clk, with the first start accepted at the first rising edge after deassertion.

Verification
REQ-034 SHALL verify that num_vecs=1 with resp_data=0 gives sig=32'hFFBF_FFF9, vec_cnt=1, done=1 one cycle after the beat, and pass=1 when exp_sig=32'hFFBF_FFF9.
REQ-035 SHALL verify that num_vecs=1 with resp_data=96'h1 gives sig=32'hFFBF_FFF8, and that exp_sig=32'hFFBF_FFF9 then gives pass=0.
REQ-036 SHALL verify that num_vecs=0 followed by start gives done=1 the next cycle, sig=32'hFFFF_FFFF, vec_cnt=0, and resp_ready never high.
REQ-037 SHALL verify that num_vecs=4 with resp_valid toggling 1,0,1,0,1,1 gives exactly 4 accepted beats, done after the 4th, and sig equal to a model sig with idle cycles skipped.
REQ-038 SHALL verify that rst asserted mid-edge-cycle during RUN after 2 of 5 beats gives sig=SEED, vec_cnt=0, state IDLE, and resp_ready=0 before the next clk edge.
REQ-039 SHALL verify that start pulsed in RUN with num_vecs changed leaves target and sig unaffected and completes the run with the original count.

Source files
------------

// File: rtl/out_data_misr.sv
// out_data_misr: multiple-input signature register that compacts a stream of
// response beats into a SIG_W-bit signature and compares it with a golden
// value. A run is started with a pulse on start and ends after num_vecs beats.
module out_data_misr #(
    parameter int               DATA_W = 96,
    parameter int               SIG_W  = 32,
    parameter int               CNT_W  = 16,
    parameter logic [SIG_W-1:0] SEED   = 32'hFFFF_FFFF,
    parameter logic [SIG_W-1:0] POLY   = 32'h0040_0007
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_vecs,
    input  logic              resp_valid,
    output logic              resp_ready,
    input  logic [DATA_W-1:0] resp_data,
    input  logic [SIG_W-1:0]  exp_sig,
    output logic [SIG_W-1:0]  sig,
    output logic [CNT_W-1:0]  vec_cnt,
    output logic              done,
    output logic              pass
);

    // The response is zero-extended to a whole number of signature-wide
    // slices so that any DATA_W folds cleanly.
    localparam int NSLICE = (DATA_W + SIG_W - 1) / SIG_W;
    localparam int PAD_W  = NSLICE * SIG_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // XOR every SIG_W slice of the (zero-extended) response together.
    function automatic logic [SIG_W-1:0] fold_beat(input logic [DATA_W-1:0] data);
        logic [PAD_W-1:0] padded;
        logic [SIG_W-1:0] acc;
        padded             = '0;
        padded[DATA_W-1:0] = data;
        acc                = '0;
        for (int k = 0; k < NSLICE; k++) begin
            acc = acc ^ padded[k*SIG_W +: SIG_W];
        end
        return acc;
    endfunction

    // One Galois-style shift of the signature with the folded beat mixed in.
    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] cur,
                                                   input logic [SIG_W-1:0] fold);
        logic [SIG_W-1:0] feedback;
        feedback = cur[SIG_W-1] ? POLY : '0;
        return {cur[SIG_W-2:0], 1'b0} ^ feedback ^ fold;
    endfunction

    state_t           r_state;
    state_t           w_next_state;
    logic [SIG_W-1:0] r_sig;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_target;

    logic             w_ready;
    logic             w_done;
    logic             w_accept;
    logic             w_start_ok;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [SIG_W-1:0] w_fold;
    logic [SIG_W-1:0] w_sig_next;

    // start is only honoured outside RUN; an in-flight run cannot be restarted.
    assign w_start_ok = start & (r_state != RUN);
    // A beat is taken whenever the source offers one while the block is ready.
    assign w_accept   = resp_valid & w_ready;
    // Counter wraps naturally at 2^CNT_W.
    assign w_cnt_inc  = r_cnt + CNT_W'(1);
    assign w_fold     = fold_beat(resp_data);
    assign w_sig_next = misr_step(r_sig, w_fold);

    // State register; reset forces IDLE immediately, independent of clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and state-decoded outputs; ready depends only on state.
    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = (num_vecs != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                w_ready = 1'b1;
                // The beat that brings the count up to target ends the run.
                if (resp_valid && (w_cnt_inc == r_target)) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_done = 1'b1;
                if (start) begin
                    w_next_state = (num_vecs != '0) ? RUN : DONE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Signature, beat counter and target; start takes priority and never
    // coincides with an accepted beat because ready is low outside RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig    <= SEED;
            r_cnt    <= '0;
            r_target <= '0;
        end else if (w_start_ok) begin
            r_sig    <= SEED;
            r_cnt    <= '0;
            r_target <= num_vecs;
        end else if (w_accept) begin
            r_sig    <= w_sig_next;
            r_cnt    <= w_cnt_inc;
        end
    end

    assign resp_ready = w_ready;
    assign done       = w_done;
    assign sig        = r_sig;
    assign vec_cnt    = r_cnt;
    // Combinational so a change of the golden value in DONE shows at once.
    assign pass       = w_done & (r_sig == exp_sig);

endmodule
